intt: RTL and testbench

Inverse number-theoretic transform for ML-KEM (q = 3329, n = 256, 12-bit coefficients). It takes a 256-entry NTT-domain vector, of the kind produced by the forward `ntt` block, and returns the normal-domain polynomial. The computation uses the FIPS 203 Algorithm 10 Gentleman-Sande schedule on a single butterfly unit, followed by a final scaling pass. It uses the same level-held `start_i` / `done_o` control convention as `ntt`, so both blocks drop into the same datapath controller.

---
 rtl/intt_if.sv | 22 ++
 rtl/intt.sv | 142 ++++++++++++++
 tb/tb_intt.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/intt_if.sv
// Control and coefficient bus for the inverse NTT: level-held start, registered
// done, and the full 256-coefficient input and result arrays.
interface intt_if;
    logic        start_i;
    logic        done_o;
    logic [11:0] coeff_i [256];
    logic [11:0] coeff_o [256];

    modport master (
        output start_i,
        output coeff_i,
        input  done_o,
        input  coeff_o
    );

    modport slave (
        input  start_i,
        input  coeff_i,
        output done_o,
        output coeff_o
    );
endinterface

// File: rtl/intt.sv
// ML-KEM inverse NTT: Gentleman-Sande butterflies on one shared modular multiplier,
// one butterfly per cycle over 7 layers, then a 256-cycle scaling pass by 128^-1.
module intt #(
    parameter logic [11:0] Q     = 12'd3329,
    parameter logic [11:0] F_INV = 12'd3303
) (
    input  logic  clk_i,
    input  logic  rst_i,
    intt_if.slave bus
);
    // floor(2^26 / 3329): quotient estimate is at most one short for 24-bit products
    localparam logic [15:0] BARRETT_M = 16'd20158;

    typedef enum logic [2:0] {IDLE, LOAD, BFLY, SCALE, DONE} state_t;

    state_t      state_reg, state_next;
    logic        done_reg, done_next;
    logic [11:0] coeff_reg [256];
    logic [2:0]  layer_reg;
    logic [7:0]  cnt_reg;
    logic [6:0]  zeta_k_reg;

    // zeta[k] = 17^bitrev7(k) mod 3329, folded to constants at elaboration
    function automatic logic [11:0] zeta_fn(input int k);
        int br;
        int r;
        br = 0;
        for (int i = 0; i < 7; i++) begin
            if (((k >> i) & 1) != 0) br = br | (1 << (6 - i));
        end
        r = 1;
        for (int e = 0; e < br; e++) begin
            r = r * 17;
            for (int s = 0; s < 17; s++) begin
                if (r >= 3329) r = r - 3329;
            end
        end
        return 12'(r);
    endfunction

    logic [11:0] zeta_rom [128];
    for (genvar gi = 0; gi < 128; gi++) begin : g_zeta
        assign zeta_rom[gi] = zeta_fn(gi);
    end

    logic [7:0]  len, grp, offs, j_idx, jl_idx;
    logic [11:0] t_val, u_val, sum_mod, diff_mod;
    logic [11:0] mul_a, mul_b, prod_mod;
    logic [12:0] sum_raw;
    logic [23:0] prod, rem;
    logic [13:0] qest;

    always_comb begin
        len     = 8'd2 << layer_reg;
        grp     = {1'b0, cnt_reg[6:0]} >> ({1'b0, layer_reg} + 4'd1);
        offs    = cnt_reg & (len - 8'd1);
        j_idx   = (grp << ({1'b0, layer_reg} + 4'd2)) | offs;
        jl_idx  = j_idx + len;
        t_val   = coeff_reg[j_idx];
        u_val   = coeff_reg[jl_idx];

        sum_raw = {1'b0, t_val} + {1'b0, u_val};
        sum_mod = (sum_raw >= {1'b0, Q}) ? 12'(sum_raw - {1'b0, Q}) : sum_raw[11:0];
        // modulo-4096 wrap is harmless: the true result is below Q
        diff_mod = (u_val >= t_val) ? (u_val - t_val) : (u_val + Q - t_val);

        if (state_reg == SCALE) begin
            mul_a = F_INV;
            mul_b = coeff_reg[cnt_reg];
        end else begin
            mul_a = zeta_rom[zeta_k_reg];
            mul_b = diff_mod;
        end

        prod     = 24'(mul_a) * 24'(mul_b);
        qest     = 14'((40'(prod) * 40'(BARRETT_M)) >> 26);
        rem      = prod - 24'(qest) * 24'(Q);
        prod_mod = (rem >= 24'(Q)) ? 12'(rem - 24'(Q)) : rem[11:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.start_i) state_next = LOAD;
            LOAD:  state_next = BFLY;
            BFLY:  if (layer_reg == 3'd6 && cnt_reg[6:0] == 7'd127) state_next = SCALE;
            SCALE: if (cnt_reg == 8'd255) state_next = DONE;
            DONE:  state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (state_reg != IDLE && !bus.start_i) state_next = IDLE;
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            done_reg   <= 1'b0;
            layer_reg  <= 3'd0;
            cnt_reg    <= 8'd0;
            zeta_k_reg <= 7'd127;
            for (int i = 0; i < 256; i++) coeff_reg[i] <= 12'd0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            case (state_reg)
                IDLE: begin
                    layer_reg  <= 3'd0;
                    cnt_reg    <= 8'd0;
                    zeta_k_reg <= 7'd127;
                    for (int i = 0; i < 256; i++) coeff_reg[i] <= 12'd0;
                end
                LOAD: begin
                    for (int i = 0; i < 256; i++) begin
                        coeff_reg[i] <= (bus.coeff_i[i] >= Q) ? (bus.coeff_i[i] - Q) : bus.coeff_i[i];
                    end
                end
                BFLY: begin
                    coeff_reg[j_idx]  <= sum_mod;
                    coeff_reg[jl_idx] <= prod_mod;
                    if (offs == len - 8'd1) zeta_k_reg <= zeta_k_reg - 7'd1;
                    if (cnt_reg[6:0] == 7'd127) begin
                        cnt_reg   <= 8'd0;
                        layer_reg <= layer_reg + 3'd1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                SCALE: begin
                    coeff_reg[cnt_reg] <= prod_mod;
                    cnt_reg            <= cnt_reg + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done_o = done_reg;
    for (genvar gi = 0; gi < 256; gi++) begin : g_out
        assign bus.coeff_o[gi] = coeff_reg[gi];
    end
endmodule

// File: tb/tb_intt.sv
// Scoreboard bench for intt: golden forward NTT of random polynomials feeds the
// DUT, a monitor checks each result against the original polynomial.
module tb_intt;
    localparam int QM = 3329;
    localparam int RANDOM_RUNS = 36;

    typedef logic [255:0][11:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    intt_if bus ();

    intt dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   txn_cnt   = 0;
    vec_t exp_q [$];
    int   zt [128];

    task automatic check(input bit ok, input string name, input string detail);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic int first_diff(input vec_t v);
        for (int i = 0; i < 256; i++) begin
            if (bus.coeff_o[i] !== v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit all_zero();
        for (int i = 0; i < 256; i++) begin
            if (bus.coeff_o[i] !== 12'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // FIPS 203 Algorithm 9, the forward transform the DUT must invert
    function automatic vec_t fwd_ntt(input vec_t p);
        int   f [256];
        int   k;
        vec_t r;
        for (int i = 0; i < 256; i++) f[i] = int'(p[i]);
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                int z;
                z = zt[k];
                k++;
                for (int j = st; j < st + len; j++) begin
                    int t;
                    t = (z * f[j + len]) % QM;
                    f[j + len] = (f[j] - t + QM) % QM;
                    f[j]       = (f[j] + t) % QM;
                end
            end
        end
        for (int i = 0; i < 256; i++) r[i] = 12'(f[i]);
        return r;
    endfunction

    // Monitor: pops one expected polynomial per rising done_o
    bit done_prev;
    always @(negedge clk) begin
        if (bus.done_o === 1'b1 && !done_prev) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "sb_unexpected_done", "done_o rose with no expected result queued");
            end else begin
                vec_t ve;
                int   d;
                ve = exp_q.pop_front();
                d  = first_diff(ve);
                txn_cnt++;
                check(d < 0, "sb_result",
                      (d < 0) ? "" : $sformatf("txn %0d coeff[%0d] got %0d want %0d",
                                               txn_cnt, d, bus.coeff_o[d], ve[d]));
                $display("txn %0d: result compared, coeff[0]=%0d coeff[1]=%0d", txn_cnt,
                         bus.coeff_o[0], bus.coeff_o[1]);
            end
        end
        done_prev = (bus.done_o === 1'b1);
    end

    task automatic drive(input vec_t v);
        for (int i = 0; i < 256; i++) bus.coeff_i[i] = v[i];
    endtask

    task automatic wait_done(input int expect_n, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 1300) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done_o === 1'b1) seen = 1'b1;
        end
        check(seen && n == expect_n, {name, "_latency"},
              $sformatf("done seen %0b after %0d edges, want %0d", seen, n, expect_n));
    endtask

    task automatic finish_run(input vec_t vexp, input string name);
        int d;
        repeat (3) @(posedge clk);
        #1;
        check(bus.done_o === 1'b1, {name, "_done_held"}, $sformatf("done_o %b want 1", bus.done_o));
        d = first_diff(vexp);
        check(d < 0, {name, "_frozen"},
              (d < 0) ? "" : $sformatf("coeff[%0d] %0d want %0d", d, bus.coeff_o[d], vexp[d]));
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check(bus.done_o === 1'b0, {name, "_drop"}, $sformatf("done_o %b want 0", bus.done_o));
        @(posedge clk);
        #1;
        check(all_zero(), {name, "_cleared"}, "coeff_o not all zero after return to IDLE");
    endtask

    task automatic run(input vec_t vin, input vec_t vexp, input string name);
        drive(vin);
        exp_q.push_back(vexp);
        @(negedge clk);
        bus.start_i = 1'b1;
        wait_done(1154, name);
        finish_run(vexp, name);
    endtask

    vec_t v_zero, v_c5, v_c5_exp, v_x, v_x_exp, v_c5_hi, p, x;

    initial begin
        for (int k = 0; k < 128; k++) begin
            int br, r;
            br = 0;
            for (int i = 0; i < 7; i++) if (((k >> i) & 1) != 0) br |= (1 << (6 - i));
            r = 1;
            for (int e = 0; e < br; e++) r = (r * 17) % QM;
            zt[k] = r;
        end

        v_zero = '0; v_c5 = '0; v_c5_exp = '0; v_x = '0; v_x_exp = '0; v_c5_hi = '0;
        for (int i = 0; i < 128; i++) begin
            v_c5[2 * i]        = 12'd5;
            v_x[2 * i + 1]     = 12'd1;
            v_c5_hi[2 * i]     = 12'd3334;
        end
        v_c5_exp[0] = 12'd5;
        v_x_exp[1]  = 12'd1;

        rst = 1'b1;
        bus.start_i = 1'b0;
        drive(v_zero);
        repeat (3) @(posedge clk);
        #1;
        check(bus.done_o === 1'b0 && all_zero(), "reset_state",
              $sformatf("done_o %b, coeff zero %0b; want 0 and 1", bus.done_o, all_zero()));
        rst = 1'b0;
        @(posedge clk);

        run(v_zero, v_zero, "all_zero");
        run(v_c5, v_c5_exp, "const5");
        run(v_x, v_x_exp, "poly_x");
        run(v_c5_hi, v_c5_exp, "const5_oor");

        // abort at E500: no result may ever be presented for this run
        drive(v_c5);
        @(negedge clk);
        bus.start_i = 1'b1;
        repeat (499) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check(bus.done_o === 1'b0, "abort_done", $sformatf("done_o %b want 0", bus.done_o));
        @(posedge clk);
        #1;
        check(all_zero(), "abort_cleared", "coeff_o not all zero one edge after abort");
        repeat (4) @(posedge clk);
        run(v_c5, v_c5_exp, "after_abort");

        // reset pulse at E700 with start held; the run restarts from scratch
        drive(v_x);
        exp_q.push_back(v_x_exp);
        @(negedge clk);
        bus.start_i = 1'b1;
        repeat (699) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check(bus.done_o === 1'b0 && all_zero(), "reset_mid",
              $sformatf("done_o %b coeff zero %0b after reset edge", bus.done_o, all_zero()));
        rst = 1'b0;
        wait_done(1154, "after_reset");
        finish_run(v_x_exp, "after_reset");

        for (int r = 0; r < RANDOM_RUNS; r++) begin
            for (int i = 0; i < 256; i++) p[i] = 12'($urandom_range(0, QM - 1));
            x = fwd_ntt(p);
            // some small entries are lifted into 3329..4095 to exercise the load reduction
            for (int i = 0; i < 256; i++) begin
                if (x[i] < 12'd767 && $urandom_range(0, 3) == 0) x[i] = x[i] + 12'(QM);
            end
            run(x, p, $sformatf("rand%0d", r));
        end

        repeat (4) @(posedge clk);
        check(exp_q.size() == 0, "sb_drained", $sformatf("%0d expected results never presented", exp_q.size()));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
